tracker_axis_scheduler: RTL and testbench

// - Sequences the two tracker axes (teta = vertical, fi = horizontal) over one shared motor driver;
//   at most one motor is energised at any time.
// - Auto mode (s=1) balances photoresistor pairs; manual mode (s=0) drives actual position to target.
// - Each move is a timed pulse followed by a settle window before the next measurement.
// - Sits between sensor/position registers and the motor H-bridges.

---
 rtl/tracker_pkg.sv | 20 ++
 rtl/tracker_axis_scheduler_if.sv | 35 +++
 rtl/axis_comparator.sv | 26 ++
 rtl/tracker_axis_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tracker_axis_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tracker_pkg.sv
// Shared definitions for the two-axis tracker scheduler:
// motor drive codes, axis ids and FSM state encoding.
package tracker_pkg;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_CW   = 2'b01;
   localparam logic [1:0] MOT_CCW  = 2'b11;

   localparam logic AXIS_TETA = 1'b0;
   localparam logic AXIS_FI   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVAL,
      ST_MOVE,
      ST_SETTLE,
      ST_FAULT
   } state_t;

endpackage

// File: rtl/tracker_axis_scheduler_if.sv
// Sensor/position inputs, mode select and motor/status outputs
// of the tracker scheduler, bundled as one interface.
interface tracker_axis_scheduler_if #(
   parameter int W = 16
);
   logic         s;
   logic [W-1:0] R_vertical_1;
   logic [W-1:0] R_vertical_2;
   logic [W-1:0] R_horizontal_1;
   logic [W-1:0] R_horizontal_2;
   logic [W-1:0] teta_manual;
   logic [W-1:0] teta_actual;
   logic [W-1:0] fi_manual;
   logic [W-1:0] fi_actual;
   logic [1:0]   s_out_teta;
   logic [1:0]   s_out_fi;
   logic         busy;
   logic         fault;

   modport master (
      output s, R_vertical_1, R_vertical_2,
      output R_horizontal_1, R_horizontal_2,
      output teta_manual, teta_actual,
      output fi_manual, fi_actual,
      input  s_out_teta, s_out_fi, busy, fault
   );

   modport slave (
      input  s, R_vertical_1, R_vertical_2,
      input  R_horizontal_1, R_horizontal_2,
      input  teta_manual, teta_actual,
      input  fi_manual, fi_actual,
      output s_out_teta, s_out_fi, busy, fault
   );
endinterface

// File: rtl/axis_comparator.sv
// Compares one (a,b) pair without wrap and reports whether it is
// within the deadband and, if not, which way the motor must turn.
module axis_comparator
   import tracker_pkg::*;
#(
   parameter int W        = 16,
   parameter int DEADBAND = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         balanced,
   output logic [1:0]   dir
);

   logic [W:0] diff;

   // absolute difference at W+1 bits, then deadband and direction
   always_comb begin
      diff = (a >= b) ? ({1'b0, a} - {1'b0, b})
                      : ({1'b0, b} - {1'b0, a});
      balanced = (diff <= (W+1)'(DEADBAND));
      dir = MOT_STOP;
      if (!balanced) dir = (a > b) ? MOT_CW : MOT_CCW;
   end

endmodule

// File: rtl/tracker_axis_scheduler.sv
// Time-multiplexes one motor driver between the teta and fi axes:
// evaluate, pulse, settle, repeat; idle once both axes balance.
module tracker_axis_scheduler
   import tracker_pkg::*;
#(
   parameter int W             = 16,
   parameter int DEADBAND      = 1,
   parameter int STEP_CYCLES   = 50000,
   parameter int SETTLE_CYCLES = 20000,
   parameter int IDLE_CYCLES   = 100000,
   parameter int MAX_STEPS     = 255
) (
   input logic                     clk,
   input logic                     rst,
   tracker_axis_scheduler_if.slave bus
);

   localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] IDLE_LAST   = 32'(IDLE_CYCLES - 1);
   localparam logic [31:0] STEP_MAX    = 32'(MAX_STEPS);

   state_t      state, state_d;
   logic        axis, axis_d;
   logic        bal_t, bal_t_d;
   logic        bal_f, bal_f_d;
   logic [31:0] timer, timer_d;
   logic [31:0] step_cnt, step_d;
   logic [1:0]  dir_q, dir_d;
   logic        s_q, s_vld, chg;
   logic [W-1:0] cmp_a, cmp_b;
   logic        cmp_bal;
   logic [1:0]  cmp_dir;
   logic        other_bal;
   logic [1:0]  teta_d, fi_d;
   logic        busy_d, fault_d;

   // pick the compare pair for the current axis and mode
   always_comb begin
      cmp_a = bus.teta_manual;
      cmp_b = bus.teta_actual;
      unique case ({bus.s, axis})
         {1'b1, AXIS_TETA}: begin
            cmp_a = bus.R_vertical_1;
            cmp_b = bus.R_vertical_2;
         end
         {1'b1, AXIS_FI}: begin
            cmp_a = bus.R_horizontal_1;
            cmp_b = bus.R_horizontal_2;
         end
         {1'b0, AXIS_FI}: begin
            cmp_a = bus.fi_manual;
            cmp_b = bus.fi_actual;
         end
         default: ;
      endcase
   end

   axis_comparator #(.W(W), .DEADBAND(DEADBAND)) u_cmp (
      .a        (cmp_a),
      .b        (cmp_b),
      .balanced (cmp_bal),
      .dir      (cmp_dir)
   );

   // s_vld masks the first cycle so reset never looks like a mode edge
   assign chg       = s_vld && (bus.s != s_q);
   assign other_bal = (axis == AXIS_TETA) ? bal_f : bal_t;

   // next-state, counters and registered-output targets
   always_comb begin
      state_d = state;
      axis_d  = axis;
      bal_t_d = bal_t;
      bal_f_d = bal_f;
      step_d  = step_cnt;
      dir_d   = dir_q;
      timer_d = (timer == '1) ? timer : timer + 32'd1;
      unique case (state)
         ST_EVAL: begin
            timer_d = '0;
            if (!cmp_bal) begin
               if (step_cnt == STEP_MAX) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_MOVE;
                  dir_d   = cmp_dir;
                  step_d  = step_cnt + 32'd1;
               end
            end else if (other_bal) begin
               state_d = ST_IDLE;
            end else begin
               if (axis == AXIS_TETA) bal_t_d = 1'b1;
               else                   bal_f_d = 1'b1;
               axis_d = ~axis;
               step_d = '0;
            end
         end
         ST_MOVE: begin
            if (timer >= STEP_LAST) begin
               state_d = ST_SETTLE;
               timer_d = '0;
            end
         end
         ST_SETTLE: begin
            if (timer >= SETTLE_LAST) begin
               state_d = ST_EVAL;
               timer_d = '0;
            end
         end
         ST_IDLE: begin
            if (timer >= IDLE_LAST) begin
               state_d = ST_EVAL;
               timer_d = '0;
               axis_d  = AXIS_TETA;
               bal_t_d = 1'b0;
               bal_f_d = 1'b0;
            end
         end
         ST_FAULT: ;
         default: state_d = ST_EVAL;
      endcase
      if (chg) begin
         state_d = ST_SETTLE;
         timer_d = '0;
         step_d  = '0;
         bal_t_d = 1'b0;
         bal_f_d = 1'b0;
         axis_d  = AXIS_TETA;
      end
      teta_d  = (state_d == ST_MOVE && axis_d == AXIS_TETA) ? dir_d : MOT_STOP;
      fi_d    = (state_d == ST_MOVE && axis_d == AXIS_FI)   ? dir_d : MOT_STOP;
      busy_d  = (state_d == ST_EVAL) || (state_d == ST_MOVE) ||
                (state_d == ST_SETTLE);
      fault_d = (state_d == ST_FAULT);
   end

   // state, counters and outputs, all cleared by async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_EVAL;
         axis           <= AXIS_TETA;
         bal_t          <= 1'b0;
         bal_f          <= 1'b0;
         timer          <= '0;
         step_cnt       <= '0;
         dir_q          <= MOT_STOP;
         s_q            <= 1'b0;
         s_vld          <= 1'b0;
         bus.s_out_teta <= MOT_STOP;
         bus.s_out_fi   <= MOT_STOP;
         bus.busy       <= 1'b0;
         bus.fault      <= 1'b0;
      end else begin
         state          <= state_d;
         axis           <= axis_d;
         bal_t          <= bal_t_d;
         bal_f          <= bal_f_d;
         timer          <= timer_d;
         step_cnt       <= step_d;
         dir_q          <= dir_d;
         s_q            <= bus.s;
         s_vld          <= 1'b1;
         bus.s_out_teta <= teta_d;
         bus.s_out_fi   <= fi_d;
         bus.busy       <= busy_d;
         bus.fault      <= fault_d;
      end
   end

endmodule

// File: tb/tb_tracker_axis_scheduler.sv
// Directed scenarios and a random sweep for the tracker scheduler,
// with cycle-exact expected motor/status values.
module tb_tracker_axis_scheduler;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   tracker_axis_scheduler_if #(.W(16)) bus ();

   tracker_axis_scheduler #(
      .W             (16),
      .DEADBAND      (2),
      .STEP_CYCLES   (4),
      .SETTLE_CYCLES (3),
      .IDLE_CYCLES   (5),
      .MAX_STEPS     (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s,
                         input int rv1, input int rv2,
                         input int rh1, input int rh2,
                         input int tm, input int ta,
                         input int fm, input int fa);
      bus.s              = s;
      bus.R_vertical_1   = 16'(rv1);
      bus.R_vertical_2   = 16'(rv2);
      bus.R_horizontal_1 = 16'(rh1);
      bus.R_horizontal_2 = 16'(rh2);
      bus.teta_manual    = 16'(tm);
      bus.teta_actual    = 16'(ta);
      bus.fi_manual      = 16'(fm);
      bus.fi_actual      = 16'(fa);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_in(1'b1, 100, 50, 70, 70, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b00 || bus.s_out_fi !== 2'b00 ||
          bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got teta=%b fi=%b busy=%b fault=%b want 00 00 0 0",
                  bus.s_out_teta, bus.s_out_fi, bus.busy, bus.fault);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_first_pulse: got teta=%b want 01", bus.s_out_teta);
      end
      tick();
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.s_out_teta !== 2'b00 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got teta=%b busy=%b want 00 0",
                  bus.s_out_teta, bus.busy);
      end
      tick();
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b01 || bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: got teta=%b fault=%b busy=%b want 01 0 1",
                  bus.s_out_teta, bus.fault, bus.busy);
      end
   endtask

   task automatic test_auto_teta();
      set_in(1'b1, 100, 50, 70, 70, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (bus.s_out_teta !== 2'b01 || bus.s_out_fi !== 2'b00) begin
            n_fail++;
            $display("FAIL auto_teta_pulse[%0d]: got teta=%b fi=%b want 01 00",
                     i, bus.s_out_teta, bus.s_out_fi);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.s_out_teta !== 2'b00 || bus.s_out_fi !== 2'b00 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_teta_settle[%0d]: got teta=%b fi=%b busy=%b want 00 00 1",
                     i, bus.s_out_teta, bus.s_out_fi, bus.busy);
         end
      end
      bus.R_vertical_2 = 16'd99;
      tick();
      tick();
      tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.s_out_fi !== 2'b00 || bus.s_out_teta !== 2'b00) begin
         n_fail++;
         $display("FAIL auto_teta_idle: got busy=%b fi=%b teta=%b want 0 00 00",
                  bus.busy, bus.s_out_fi, bus.s_out_teta);
      end
      repeat (4) tick();
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL auto_idle_hold: got busy=%b want 0", bus.busy);
      end
      tick();
      n_tests++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_idle_exit: got busy=%b want 1", bus.busy);
      end
   endtask

   task automatic test_auto_fi();
      set_in(1'b1, 10, 10, 5, 40, 0, 0, 0, 0);
      do_reset();
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b00 || bus.s_out_fi !== 2'b00 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_fi_skip: got teta=%b fi=%b busy=%b want 00 00 1",
                  bus.s_out_teta, bus.s_out_fi, bus.busy);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (bus.s_out_fi !== 2'b11 || bus.s_out_teta !== 2'b00) begin
            n_fail++;
            $display("FAIL auto_fi_pulse[%0d]: got fi=%b teta=%b want 11 00",
                     i, bus.s_out_fi, bus.s_out_teta);
         end
      end
      bus.R_horizontal_1 = 16'd39;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.s_out_fi !== 2'b00) begin
            n_fail++;
            $display("FAIL auto_fi_settle[%0d]: got fi=%b want 00", i, bus.s_out_fi);
         end
      end
      tick();
      tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.s_out_fi !== 2'b00) begin
         n_fail++;
         $display("FAIL auto_fi_idle: got busy=%b fi=%b want 0 00",
                  bus.busy, bus.s_out_fi);
      end
   endtask

   task automatic test_manual_fault();
      int on_cnt;
      on_cnt = 0;
      set_in(1'b0, 0, 0, 0, 0, 200, 0, 0, 0);
      do_reset();
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (bus.s_out_teta == 2'b01) on_cnt++;
         if (i == 24) begin
            n_tests++;
            if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL manual_pre_fault: got fault=%b busy=%b want 0 1",
                        bus.fault, bus.busy);
            end
         end
      end
      n_tests++;
      if (on_cnt !== 12) begin
         n_fail++;
         $display("FAIL manual_pulse_cycles: got %0d want 12", on_cnt);
      end
      tick();
      n_tests++;
      if (bus.fault !== 1'b1 || bus.busy !== 1'b0 ||
          bus.s_out_teta !== 2'b00 || bus.s_out_fi !== 2'b00) begin
         n_fail++;
         $display("FAIL manual_fault: got fault=%b busy=%b teta=%b fi=%b want 1 0 00 00",
                  bus.fault, bus.busy, bus.s_out_teta, bus.s_out_fi);
      end
      repeat (3) tick();
      n_tests++;
      if (bus.fault !== 1'b1) begin
         n_fail++;
         $display("FAIL manual_fault_sticky: got fault=%b want 1", bus.fault);
      end
      bus.s = 1'b1;
      tick();
      n_tests++;
      if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL manual_fault_clear: got fault=%b busy=%b want 0 1",
                  bus.fault, bus.busy);
      end
   endtask

   task automatic test_mode_toggle();
      set_in(1'b1, 10, 10, 5, 40, 50, 0, 0, 0);
      do_reset();
      tick();
      tick();
      tick();
      n_tests++;
      if (bus.s_out_fi !== 2'b11) begin
         n_fail++;
         $display("FAIL toggle_pre: got fi=%b want 11", bus.s_out_fi);
      end
      bus.s = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.s_out_fi !== 2'b00 || bus.s_out_teta !== 2'b00 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_settle[%0d]: got fi=%b teta=%b busy=%b want 00 00 1",
                     i, bus.s_out_fi, bus.s_out_teta, bus.busy);
         end
      end
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b00 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL toggle_eval: got teta=%b busy=%b want 00 1",
                  bus.s_out_teta, bus.busy);
      end
      tick();
      n_tests++;
      if (bus.s_out_teta !== 2'b01 || bus.s_out_fi !== 2'b00) begin
         n_fail++;
         $display("FAIL toggle_teta_axis: got teta=%b fi=%b want 01 00",
                  bus.s_out_teta, bus.s_out_fi);
      end
   endtask

   task automatic test_random_sweep();
      set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         bus.R_vertical_1   = 16'($urandom_range(0, 40));
         bus.R_vertical_2   = 16'($urandom_range(0, 40));
         bus.R_horizontal_1 = 16'($urandom_range(0, 40));
         bus.R_horizontal_2 = 16'($urandom_range(0, 40));
         bus.teta_manual    = 16'($urandom_range(0, 40));
         bus.teta_actual    = 16'($urandom_range(0, 40));
         bus.fi_manual      = 16'($urandom_range(0, 40));
         bus.fi_actual      = 16'($urandom_range(0, 40));
         if ($urandom_range(0, 199) == 0) bus.s = ~bus.s;
         tick();
         n_tests++;
         if ((bus.s_out_teta != 2'b00 && bus.s_out_fi != 2'b00) ||
             bus.s_out_teta === 2'b10 || bus.s_out_fi === 2'b10) begin
            n_fail++;
            $display("FAIL sweep_invariant[%0d]: got teta=%b fi=%b want one-hot legal",
                     i, bus.s_out_teta, bus.s_out_fi);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_auto_teta();
      test_auto_fi();
      test_manual_fault();
      test_mode_toggle();
      test_random_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
